// File: rtl/ringbuffer_drain.sv
// Drains one ringbuffer entry per frame and serialises it to a byte stream:
// a header byte carrying the overflow flag, then the entry MSB byte first.
module ringbuffer_drain #(
   parameter int unsigned DW  = 32,
   parameter logic [7:0]  HDR = 8'hA4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          empty,
   input  logic          overflow,
   input  logic [DW-1:0] mem_data,
   output logic          read_clock_enable,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          busy
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned CW = $clog2(NB + 1);
   localparam logic [CW-1:0] NBC = CW'(NB);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HDR,
      S_DATA
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          sent_q, sent_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sent_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sent_q  <= sent_d;
      end
   end

   // sent_q freezes the header's flag bit so the byte stays stable under stall;
   // only a reported overflow is cleared on header acceptance.
   always_comb begin
      state_d           = state_q;
      shift_d           = shift_q;
      cnt_d             = cnt_q;
      sent_d            = sent_q;
      ovf_d             = ovf_q | overflow;
      read_clock_enable = 1'b0;
      tx_valid          = 1'b0;
      tx_data           = 8'h00;
      busy              = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (!empty) state_d = S_WAIT;
         end
         S_WAIT: begin
            read_clock_enable = 1'b1;
            shift_d           = mem_data;
            sent_d            = ovf_q | overflow;
            state_d           = S_HDR;
         end
         S_HDR: begin
            tx_valid = 1'b1;
            tx_data  = {HDR[7:1], sent_q};
            if (tx_ready) begin
               cnt_d   = NBC;
               state_d = S_DATA;
               if (sent_q && !overflow) ovf_d = 1'b0;
            end
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = shift_q[DW-1 -: 8];
            if (tx_ready) begin
               shift_d = shift_q << 8;
               cnt_d   = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Directed bench for ringbuffer_drain: byte stream, pop pulses,
// overflow header flag, back-to-back frames and mid-frame reset.
module tb_ringbuffer_drain;

   logic        clock = 1'b0;
   logic        reset;
   logic        empty;
   logic        overflow;
   logic [31:0] mem_data;
   logic        read_clock_enable;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   ringbuffer_drain #(.DW(32), .HDR(8'hA4)) dut (
      .clock             (clock),
      .reset             (reset),
      .empty             (empty),
      .overflow          (overflow),
      .mem_data          (mem_data),
      .read_clock_enable (read_clock_enable),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .busy              (busy)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:3];
   logic [1:0]  ptr = 2'd0;
   assign mem_data = mem[ptr];
   always @(posedge clock) if (read_clock_enable) ptr <= ptr + 2'd1;

   int vecs = 0;
   int errs = 0;
   int pops = 0;
   int cyc  = 0;
   bit tog_mode = 0;
   logic [7:0] q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic       prev_stall = 1'b0;
   logic       prev_rce   = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   always @(negedge clock) begin
      if (prev_stall) begin
         chk("hold_valid", tx_valid, 1);
         chk("hold_data", tx_data, prev_data);
      end
      if (read_clock_enable) begin
         pops++;
         chk("pop_single", prev_rce, 0);
         chk("pop_no_tx", tx_valid, 0);
      end
      if (tx_valid && tx_ready && !reset) q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready && !reset;
      prev_data  = tx_data;
      prev_rce   = read_clock_enable && !reset;
   end

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (tog_mode) tx_ready = ~tx_ready;
   endtask

   task automatic wait_pop(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!read_clock_enable && n < 10);
      chk({tag, "_pop"}, read_clock_enable, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, busy, 0);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] d,
                            input bit tog, input logic [7:0] hdr,
                            input bit ovf_at_hdr);
      int p0;
      logic [7:0] exp_b [0:4];
      exp_b[0] = hdr;
      exp_b[1] = d[31:24];
      exp_b[2] = d[23:16];
      exp_b[3] = d[15:8];
      exp_b[4] = d[7:0];
      mem[ptr] = d;
      q.delete();
      p0 = pops;
      tx_ready = 1'b1;
      tog_mode = tog;
      empty = 1'b0;
      wait_pop(tag);
      empty = 1'b1;
      if (ovf_at_hdr) begin
         tick();
         overflow = 1'b1;
         tick();
         overflow = 1'b0;
      end
      wait_idle(tag);
      tog_mode = 0;
      tx_ready = 1'b1;
      chk({tag, "_pops"}, pops - p0, 1);
      chk({tag, "_len"}, q.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s_b%0d", tag, i),
             (i < q.size()) ? {24'h0, q[i]} : 32'hxxxxxxxx,
             {24'h0, exp_b[i]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2, n, p0;
      logic bad;
      logic [7:0] e2 [0:9];
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;
      reset = 1'b1;
      empty = 1'b1;
      overflow = 1'b0;
      tx_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rce", read_clock_enable, 0);
      reset = 1'b0;

      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         bad = bad | read_clock_enable | tx_valid | busy;
      end
      chk("idle20", bad, 0);

      run_frame("basic", 32'h11223344, 0, 8'hA4, 0);
      run_frame("toggle", 32'h11223344, 1, 8'hA4, 0);

      overflow = 1'b1;
      tick();
      overflow = 1'b0;
      tick();
      run_frame("ovf1", 32'h89ABCDEF, 0, 8'hA5, 0);
      run_frame("ovf0", 32'h00FF00FF, 0, 8'hA4, 0);
      run_frame("ovfhdr", 32'h12345678, 0, 8'hA4, 1);
      run_frame("ovfnext", 32'h9A9B9C9D, 0, 8'hA5, 0);
      run_frame("ovfclr", 32'h01020304, 1, 8'hA4, 0);

      mem[ptr] = 32'hDEADBEEF;
      mem[ptr + 2'd1] = 32'h0102A4FF;
      e2 = '{8'hA4, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'hA4, 8'h01, 8'h02, 8'hA4, 8'hFF};
      q.delete();
      p0 = pops;
      c1 = -1;
      c2 = -1;
      n = 0;
      empty = 1'b0;
      while (c2 < 0 && n < 30) begin
         tick();
         n++;
         if (read_clock_enable) begin
            if (c1 < 0) c1 = cyc;
            else c2 = cyc;
         end
      end
      empty = 1'b1;
      wait_idle("b2b");
      chk("b2b_gap", c2 - c1, 7);
      chk("b2b_pops", pops - p0, 2);
      chk("b2b_len", q.size(), 10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("b2b_b%0d", i),
             (i < q.size()) ? {24'h0, q[i]} : 32'hxxxxxxxx,
             {24'h0, e2[i]});

      mem[ptr] = 32'h55667788;
      q.delete();
      p0 = pops;
      empty = 1'b0;
      wait_pop("rst");
      empty = 1'b1;
      tick();
      tick();
      overflow = 1'b1;
      tick();
      overflow = 1'b0;
      reset = 1'b1;
      tick();
      chk("midrst_valid", tx_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rce", read_clock_enable, 0);
      chk("midrst_data", tx_data, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("midrst_pops", pops - p0, 1);
      chk("midrst_len", q.size(), 2);
      run_frame("postrst", 32'hCAFEF00D, 0, 8'hA4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
